// File: rtl/abs_val_peak_if.sv
// Sample/result bundle for abs_val_peak: the master drives samples and clear,
// the slave returns the per-sample magnitude and the per-window peak.
interface abs_val_peak_if #(
  parameter int WIDTH  = 9,
  parameter int WINDOW = 16
);
  localparam int IW = $clog2(WINDOW);

  logic             in_valid;
  logic [WIDTH-1:0] v;
  logic             clear;
  logic             absv_valid;
  logic [WIDTH-2:0] absv;
  logic             min_flag;
  logic             peak_valid;
  logic [WIDTH-2:0] peak;
  logic [IW-1:0]    peak_index;

  modport master (
    output in_valid, v, clear,
    input  absv_valid, absv, min_flag, peak_valid, peak, peak_index
  );

  modport slave (
    input  in_valid, v, clear,
    output absv_valid, absv, min_flag, peak_valid, peak, peak_index
  );
endinterface

// File: rtl/abs_val_peak.sv
// Absolute value of a signed sample stream plus peak-of-window tracker.
// Optional macro ABS_VAL_SATURATE_EN: saturate the most-negative input's magnitude to all ones.
module abs_val_peak #(
  parameter int WIDTH  = 9,
  parameter int WINDOW = 16
) (
  input logic          clk,
  input logic          rst,
  abs_val_peak_if.slave bus
);
  localparam int IW = $clog2(WINDOW);
  localparam int AW = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {AW{1'b0}}};
  localparam logic [IW-1:0]    LAST_IDX = IW'(WINDOW - 1);

  typedef enum logic [0:0] {FILL = 1'b0, EMIT = 1'b1} state_t;

  function automatic logic [AW-1:0] mag(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] neg;
    neg = ~s + {{(WIDTH-1){1'b0}}, 1'b1};
    if (!s[WIDTH-1]) begin
      mag = s[AW-1:0];
    end else if (s == MOST_NEG) begin
`ifdef ABS_VAL_SATURATE_EN
      mag = {AW{1'b1}};
`else
      mag = neg[AW-1:0];
`endif
    end else begin
      mag = neg[AW-1:0];
    end
  endfunction

  logic          absv_valid_q, absv_valid_d;
  logic [AW-1:0] absv_q, absv_d;
  logic          min_flag_q, min_flag_d;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] run_max_q, run_max_d;
  logic [IW-1:0] run_idx_q, run_idx_d;
  logic          peak_valid_q, peak_valid_d;
  logic [AW-1:0] peak_q, peak_d;
  logic [IW-1:0] peak_index_q, peak_index_d;

  always_comb begin
    absv_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      absv_d     = mag(bus.v);
      min_flag_d = (bus.v == MOST_NEG);
    end else begin
      absv_d     = absv_q;
      min_flag_d = min_flag_q;
    end
  end

  // Clear wins over the stage-1 sample; an EMIT-cycle sample opens the next window.
  always_comb begin
    state_d      = FILL;
    cnt_d        = cnt_q;
    run_max_d    = run_max_q;
    run_idx_d    = run_idx_q;
    peak_d       = peak_q;
    peak_index_d = peak_index_q;
    if (bus.clear) begin
      cnt_d = {IW{1'b0}};
    end else if (absv_valid_q) begin
      if (cnt_q == {IW{1'b0}}) begin
        run_max_d = absv_q;
        run_idx_d = {IW{1'b0}};
      end else if (absv_q > run_max_q) begin
        run_max_d = absv_q;
        run_idx_d = cnt_q;
      end else begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
      end
      if (cnt_q == LAST_IDX) begin
        peak_d       = run_max_d;
        peak_index_d = run_idx_d;
        cnt_d        = {IW{1'b0}};
        state_d      = EMIT;
      end else begin
        cnt_d = cnt_q + {{(IW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
    case (state_d)
      EMIT:    peak_valid_d = 1'b1;
      FILL:    peak_valid_d = 1'b0;
      default: peak_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      absv_valid_q <= 1'b0;
      absv_q       <= {AW{1'b0}};
      min_flag_q   <= 1'b0;
      state_q      <= FILL;
      cnt_q        <= {IW{1'b0}};
      run_max_q    <= {AW{1'b0}};
      run_idx_q    <= {IW{1'b0}};
      peak_valid_q <= 1'b0;
      peak_q       <= {AW{1'b0}};
      peak_index_q <= {IW{1'b0}};
    end else begin
      absv_valid_q <= absv_valid_d;
      absv_q       <= absv_d;
      min_flag_q   <= min_flag_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_max_q    <= run_max_d;
      run_idx_q    <= run_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_q       <= peak_d;
      peak_index_q <= peak_index_d;
    end
  end

  assign bus.absv_valid = absv_valid_q;
  assign bus.absv       = absv_q;
  assign bus.min_flag   = min_flag_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.peak       = peak_q;
  assign bus.peak_index = peak_index_q;

  logic unused_state;
  assign unused_state = (state_q == EMIT);
endmodule

// File: tb/tb_abs_val_peak.sv
// Table-driven check of abs_val_peak at WIDTH=9, WINDOW=4, plus a mid-window reset sequence.
module tb_abs_val_peak;
  localparam int WIDTH  = 9;
  localparam int WINDOW = 4;
`ifdef ABS_VAL_SATURATE_EN
  localparam logic [7:0] MIN_ABS = 8'd255;
`else
  localparam logic [7:0] MIN_ABS = 8'd0;
`endif

  logic clk;
  logic rst;
  abs_val_peak_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

  abs_val_peak #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [8:0] v;
    logic       clr;
    logic       eav;
    logic [7:0] eabs;
    logic       emin;
    logic       epv;
    logic [7:0] epk;
    logic [1:0] eidx;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic iv, input int v, input logic clr, input logic eav,
                     input int eabs, input logic emin, input logic epv,
                     input int epk, input int eidx);
    vec_t r;
    logic [31:0] vv;
    vv     = v;
    r.iv   = iv;
    r.v    = vv[8:0];
    r.clr  = clr;
    r.eav  = eav;
    r.eabs = eabs[7:0];
    r.emin = emin;
    r.epv  = epv;
    r.epk  = epk[7:0];
    r.eidx = eidx[1:0];
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic eav, input logic [7:0] eabs,
                         input logic emin, input logic epv, input logic [7:0] epk,
                         input logic [1:0] eidx);
    n_vec++;
    chk({tag, ".absv_valid"}, 32'(bus.absv_valid), 32'(eav));
    chk({tag, ".absv"},       32'(bus.absv),       32'(eabs));
    chk({tag, ".min_flag"},   32'(bus.min_flag),   32'(emin));
    chk({tag, ".peak_valid"}, 32'(bus.peak_valid), 32'(epv));
    chk({tag, ".peak"},       32'(bus.peak),       32'(epk));
    chk({tag, ".peak_index"}, 32'(bus.peak_index), 32'(eidx));
  endtask

  task automatic drive(input logic iv, input int v, input logic clr);
    logic [31:0] vv;
    vv           = v;
    bus.in_valid = iv;
    bus.v        = vv[8:0];
    bus.clear    = clr;
  endtask

  initial begin
    // Window 1: mixed signs, peak 128 at index 2
    add(1'b1,   -5, 1'b0, 1'b1,   5, 1'b0, 1'b0,   0, 0);
    add(1'b1,    7, 1'b0, 1'b1,   7, 1'b0, 1'b0,   0, 0);
    add(1'b1, -128, 1'b0, 1'b1, 128, 1'b0, 1'b0,   0, 0);
    add(1'b1,    3, 1'b0, 1'b1,   3, 1'b0, 1'b0,   0, 0);
    add(1'b0,    0, 1'b0, 1'b0,   3, 1'b0, 1'b1, 128, 2);
    add(1'b0,    0, 1'b0, 1'b0,   3, 1'b0, 1'b0, 128, 2);
    // Tie keeps the earliest index
    add(1'b1,    9, 1'b0, 1'b1,   9, 1'b0, 1'b0, 128, 2);
    add(1'b1,   -9, 1'b0, 1'b1,   9, 1'b0, 1'b0, 128, 2);
    add(1'b1,    4, 1'b0, 1'b1,   4, 1'b0, 1'b0, 128, 2);
    add(1'b1,    9, 1'b0, 1'b1,   9, 1'b0, 1'b0, 128, 2);
    add(1'b0,    0, 1'b0, 1'b0,   9, 1'b0, 1'b1,   9, 0);
    // Back-to-back 1..8: second window starts during EMIT
    add(1'b1,    1, 1'b0, 1'b1,   1, 1'b0, 1'b0,   9, 0);
    add(1'b1,    2, 1'b0, 1'b1,   2, 1'b0, 1'b0,   9, 0);
    add(1'b1,    3, 1'b0, 1'b1,   3, 1'b0, 1'b0,   9, 0);
    add(1'b1,    4, 1'b0, 1'b1,   4, 1'b0, 1'b0,   9, 0);
    add(1'b1,    5, 1'b0, 1'b1,   5, 1'b0, 1'b1,   4, 3);
    add(1'b1,    6, 1'b0, 1'b1,   6, 1'b0, 1'b0,   4, 3);
    add(1'b1,    7, 1'b0, 1'b1,   7, 1'b0, 1'b0,   4, 3);
    add(1'b1,    8, 1'b0, 1'b1,   8, 1'b0, 1'b0,   4, 3);
    add(1'b0,    0, 1'b0, 1'b0,   8, 1'b0, 1'b1,   8, 3);
    add(1'b0,    0, 1'b0, 1'b0,   8, 1'b0, 1'b0,   8, 3);
    // Most-negative input, then a partial window killed by clear
    add(1'b1, -256, 1'b0, 1'b1, MIN_ABS, 1'b1, 1'b0, 8, 3);
    add(1'b1,   50, 1'b0, 1'b1,  50, 1'b0, 1'b0,   8, 3);
    add(1'b0,    0, 1'b1, 1'b0,  50, 1'b0, 1'b0,   8, 3);
    add(1'b1,   10, 1'b0, 1'b1,  10, 1'b0, 1'b0,   8, 3);
    add(1'b1,   20, 1'b0, 1'b1,  20, 1'b0, 1'b0,   8, 3);
    add(1'b1,   30, 1'b0, 1'b1,  30, 1'b0, 1'b0,   8, 3);
    add(1'b1,    5, 1'b0, 1'b1,   5, 1'b0, 1'b0,   8, 3);
    add(1'b0,    0, 1'b0, 1'b0,   5, 1'b0, 1'b1,  30, 2);
    add(1'b0,    0, 1'b0, 1'b0,   5, 1'b0, 1'b0,  30, 2);

    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 2'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, int'($signed(tbl[i].v)), tbl[i].clr);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].eav, tbl[i].eabs, tbl[i].emin,
              tbl[i].epv, tbl[i].epk, tbl[i].eidx);
    end

    // Reset after 3 samples of a window discards the partial window
    drive(1'b1, 100, 1'b0);
    @(posedge clk); #1;
    chk_all("mr0", 1'b1, 8'd100, 1'b0, 1'b0, 8'd30, 2'd2);
    drive(1'b1, 1, 1'b0);
    @(posedge clk); #1;
    chk_all("mr1", 1'b1, 8'd1, 1'b0, 1'b0, 8'd30, 2'd2);
    drive(1'b1, 2, 1'b0);
    @(posedge clk); #1;
    chk_all("mr2", 1'b1, 8'd2, 1'b0, 1'b0, 8'd30, 2'd2);
    drive(1'b0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 2'd0);
    @(posedge clk); #1;
    chk_all("rst_hold", 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 2'd0);
    #2 rst = 1'b0;
    drive(1'b1, 3, 1'b0);
    @(posedge clk); #1;
    chk_all("fw0", 1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 2'd0);
    drive(1'b1, 1, 1'b0);
    @(posedge clk); #1;
    chk_all("fw1", 1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 2'd0);
    drive(1'b1, 2, 1'b0);
    @(posedge clk); #1;
    chk_all("fw2", 1'b1, 8'd2, 1'b0, 1'b0, 8'd0, 2'd0);
    drive(1'b1, 1, 1'b0);
    @(posedge clk); #1;
    chk_all("fw3", 1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 2'd0);
    drive(1'b0, 0, 1'b0);
    @(posedge clk); #1;
    chk_all("fw_pulse", 1'b0, 8'd1, 1'b0, 1'b1, 8'd3, 2'd0);
    @(posedge clk); #1;
    chk_all("fw_after", 1'b0, 8'd1, 1'b0, 1'b0, 8'd3, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/abs_val_peak.md
ABS_VAL_PEAK -- requirements
Module: abs_val_peak

Interface
REQ-001 Parameter WIDTH, default 9, signed input sample width in bits; legal range 4-32.
REQ-002 Parameter WINDOW, default 16, samples per peak window; legal range 2-1024.
REQ-003 Localparam IW = clog2(WINDOW), width of the peak index field.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  v carries a sample this cycle.
REQ-007 v  input  WIDTH  signed two's-complement sample.
REQ-008 clear  input  1  synchronous restart of the current peak window.
REQ-009 absv_valid  output  1  absv/min_flag valid this cycle.
REQ-010 absv  output  WIDTH-1  unsigned magnitude of the sample.
REQ-011 min_flag  output  1  sample was the most-negative value, -2^(WIDTH-1).
REQ-012 peak_valid  output  1  one-cycle pulse; peak and peak_index valid.
REQ-013 peak  output  WIDTH-1  largest absv in the completed window.
REQ-014 peak_index  output  IW  0-based position in the window of the first occurrence of peak.

Function
REQ-015 Stage 1 SHALL register absv, min_flag and absv_valid = in_valid; latency is exactly 1 cycle, throughput 1 sample/cycle, with no backpressure.
REQ-016 absv SHALL be v when v[WIDTH-1]=0, else the two's-complement negation of v truncated to WIDTH-1 bits, except as modified by REQ-027.
REQ-017 absv and min_flag SHALL hold their last values while absv_valid=0.
REQ-018 The tracker SHALL consume only cycles with absv_valid=1, keeping a sample counter cnt (0..WINDOW-1), a running maximum run_max, and a running index run_idx.
REQ-019 The tracker SHALL have two states: FILL (accumulating) and EMIT (one cycle, peak_valid=1); it returns to FILL unconditionally after EMIT.
REQ-020 When cnt=0, the tracker SHALL load run_max=absv and run_idx=0; when cnt>0, it SHALL update only if absv>run_max (strict, so ties keep the earliest index).
REQ-021 On the sample with cnt=WINDOW-1, peak and peak_index SHALL latch the final maximum, including that sample, the FSM SHALL enter EMIT, and cnt SHALL wrap to 0.
REQ-022 peak_valid SHALL rise 1 cycle after the absv_valid of the window's last sample, i.e., 2 cycles after its in_valid.
REQ-023 A sample arriving during EMIT SHALL be counted as cnt=0 of the next window, with no sample loss for back-to-back input.
REQ-024 peak and peak_index SHALL hold between pulses.
REQ-025 clear=1 SHALL force cnt=0 and FSM=FILL; a sample in stage 1 on the same cycle is discarded by the tracker, clear takes priority, and it is still presented on absv.
REQ-026 clear SHALL NOT alter stage 1 or the held peak/peak_index; clear during EMIT still allows that pulse, and clear only prevents later pulses until a new full window is collected.

Configuration
REQ-027 Macro ABS_VAL_SATURATE_EN: when defined, a most-negative input SHALL produce absv = all ones (2^(WIDTH-1)-1); when undefined, it SHALL produce absv = 0, the truncated wrap. min_flag=1 in both cases, and the tracker uses the resulting absv.

Reset
REQ-028 reset=1 SHALL immediately clear absv_valid, absv, min_flag, peak_valid, peak, peak_index, cnt, run_max and run_idx to 0 and set FSM=FILL.
REQ-029 Reset mid-window SHALL discard the partial window, and the first valid sample after deassertion is cnt=0.
REQ-030 Reset deasserted asynchronously to clock is the integrator's responsibility; the block requires only that no in_valid occurs in the deassertion cycle.

Verification (WIDTH=9, WINDOW=4)
REQ-031 Input v=-5,+7,-128,+3 consecutively: absv=5,7,128,3 each 1 cycle after input; peak_valid 2 cycles after the +3 input, peak=128, peak_index=2.
REQ-032 Input v=-256: min_flag=1; absv=255 with ABS_VAL_SATURATE_EN defined, absv=0 without.
REQ-033 Input v=9,-9,4,9: peak=9, peak_index=0 (tie keeps the earliest).
REQ-034 Input 8 back-to-back samples 1..8: two peak_valid pulses 4 cycles apart, peak=4/idx=3 then peak=8/idx=3.
REQ-035 Input 2 samples, pulse clear, then 4 samples 10,20,30,5: exactly one peak_valid, with peak=30 and idx=2.
REQ-036 Assert reset after 3 samples of a window: all outputs read 0 during reset, and the next 4 samples form a fresh window.
